seq_divmod: RTL and testbench
=============================

// Module: seq_divmod
// PURPOSE
//   Iterative unsigned divider: one restoring-division step per clock, returning quotient
//   and remainder together, with a start/busy/done handshake and divide-by-zero error.
//   Sequential successor to the combinational modulo unit; sits between the operand
//   registers/switches and the result display path of the lab ALU.
// PARAMETERS
//   N        4   operand/result width in bits (N >= 2)
//   CNT_W    $clog2(N+1)   step counter width (derived, not overridden)
// PORTS
//   clk        in   1   system clock, all state on rising edge
//   rst        in   1   synchronous, active-high reset
//   start      in   1   request; sampled only in IDLE
//   dividend   in   N   unsigned dividend, captured on accepted start
//   divisor    in   N   unsigned divisor, captured on accepted start
//   busy       out  1   high while in CALC
//   done       out  1   one-cycle pulse: results valid
//   quotient   out  N   dividend / divisor
//   remainder  out  N   dividend % divisor
//   error      out  1   divisor was zero for the last accepted operation
// BEHAVIOUR
//   Reset (rst=1 at an edge, any state, including mid-CALC): state=IDLE, busy=0, done=0,
//   quotient=0, remainder=0, error=0, counter=0; the in-flight operation is discarded.
//   States: IDLE -> (start & divisor!=0) -> CALC; IDLE -> (start & divisor==0) -> DONE;
//   CALC -> (counter==N-1) -> DONE; DONE -> IDLE unconditionally.
//   Accept: edge k with state=IDLE and start=1 captures dividend/divisor into internal regs;
//   the ports may change afterwards without effect.
//   CALC: working regs {R (N+1 bits), Q (N bits)}; each cycle shift {R,Q} left by 1,
//   compute T = R - {1'b0,D}; if T non-negative then R=T, Q[0]=1, else Q[0]=0. Exactly N steps.
//   Latency: start accepted at edge k -> busy=1 for cycles after edges k..k+N-1,
//   done=1 for the cycle after edge k+N; quotient/remainder/error update on edge k+N.
//   Divide by zero: no CALC; done pulses the cycle after edge k+1; error=1,
//   quotient = all ones, remainder = captured dividend.
//   Successful op clears error to 0.
//   Outputs hold their last values in IDLE until the next accepted operation completes;
//   they do not change during CALC.
//   start while busy or in DONE: ignored (no queuing); start held high in IDLE after DONE
//   launches a new operation immediately (back-to-back throughput N+2 cycles).
//   busy and done never high in the same cycle.
//   Dividend < divisor: quotient=0, remainder=dividend. Dividend=0: quotient=0, remainder=0.
// STRUCTURE
//   divmod_pkg: typedef enum logic [1:0] {IDLE, CALC, DONE} divmod_state_t; any shared
//   width helpers. Sub-module divmod_step (combinational, parametrised N): inputs R,Q,D,
//   outputs next R,Q for one restoring step; instantiated once inside seq_divmod.
//   Top holds FSM, counter, operand and result registers only.
// TESTING
//   N=4: 8/2 -> after 5 edges done=1, quotient=4, remainder=0, error=0.
//   N=4: 7/3 -> quotient=2, remainder=1; busy high exactly 4 cycles before done.
//   N=4: 6/0 -> done on the 2nd edge after start, error=1, quotient=15, remainder=6;
//   a following 6/3 -> error=0, quotient=2, remainder=0.
//   N=4: start 13/4, pulse start again with 1/1 during CALC -> single result 3 r 1;
//   second request ignored.
//   N=4: start 15/2, assert rst on 2nd CALC cycle -> all outputs 0, IDLE;
//   next 9/4 -> 2 r 1.
//   N=8: 255/16 -> 15 r 15 after 9 edges; random sweep vs. reference / and % model.

Source files
------------

// File: rtl/divmod_pkg.sv
// Shared types for the sequential divider.
// Holds the FSM state encoding used by seq_divmod.
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } divmod_state_t;

endpackage

// File: rtl/divmod_step.sv
// One restoring-division step: shift {R,Q} left,
// trial-subtract D, keep the difference if no borrow.
module divmod_step #(
  parameter int N = 4
) (
  input  logic [N:0]   r_in,
  input  logic [N-1:0] q_in,
  input  logic [N-1:0] d,
  output logic [N:0]   r_out,
  output logic [N-1:0] q_out
);

  logic [N+1:0] sh;
  logic [N+1:0] d_ext;
  logic [N+1:0] diff;
  logic         ge;

  always_comb begin
    sh    = {r_in, q_in[N-1]};
    d_ext = (N+2)'(d);
    ge    = (sh >= d_ext);
    diff  = sh - d_ext;
    r_out = (N+1)'(ge ? diff : sh);
    q_out = {q_in[N-2:0], ge};
  end

endmodule

// File: rtl/seq_divmod.sv
// Iterative unsigned divider, one restoring step per clock,
// with start/busy/done handshake and divide-by-zero flag.
module seq_divmod
  import divmod_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         error
);

  localparam int CNT_W = $clog2(N+1);

  divmod_state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [N:0]       r_reg;
  logic [N-1:0]     q_reg;
  logic [N-1:0]     d_reg;
  logic             zwait;
  logic [N:0]       r_nx;
  logic [N-1:0]     q_nx;
  logic             last;

  divmod_step #(.N(N)) u_step (
    .r_in  (r_reg),
    .q_in  (q_reg),
    .d     (d_reg),
    .r_out (r_nx),
    .q_out (q_nx)
  );

  assign last = (cnt == CNT_W'(N-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A zero divisor spends one extra cycle in DONE
  // before the done pulse, with no CALC phase.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start)
              state_nx = (divisor == '0) ? DONE : CALC;
      CALC: if (last) state_nx = DONE;
      DONE: if (!zwait) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE) && !zwait;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      zwait     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      error     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          d_reg <= divisor;
          q_reg <= dividend;
          r_reg <= '0;
          cnt   <= '0;
          zwait <= (divisor == '0);
        end
        CALC: begin
          r_reg <= r_nx;
          q_reg <= q_nx;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            quotient  <= q_nx;
            remainder <= N'(r_nx);
            error     <= 1'b0;
          end
        end
        DONE: if (zwait) begin
          zwait     <= 1'b0;
          quotient  <= '1;
          remainder <= q_reg;
          error     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divmod.sv
// Directed bench for seq_divmod at N=4 and N=8.
// Expected values are hand-computed or from / and %.
module tb_seq_divmod;

  logic clk = 1'b0;
  logic rst;

  logic       st4, bz4, dn4, er4;
  logic [3:0] dd4, dv4, q4, r4;
  logic       st8, bz8, dn8, er8;
  logic [7:0] dd8, dv8, q8, r8;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_divmod #(.N(4)) u_d4 (
    .clk       (clk),
    .rst       (rst),
    .start     (st4),
    .dividend  (dd4),
    .divisor   (dv4),
    .busy      (bz4),
    .done      (dn4),
    .quotient  (q4),
    .remainder (r4),
    .error     (er4)
  );

  seq_divmod #(.N(8)) u_d8 (
    .clk       (clk),
    .rst       (rst),
    .start     (st8),
    .dividend  (dd8),
    .divisor   (dv8),
    .busy      (bz8),
    .done      (dn8),
    .quotient  (q8),
    .remainder (r8),
    .error     (er8)
  );

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d",
               tag, obs, exp);
    end
  endtask

  // Launch one op, count edges from accept to done
  // (accept edge counts as 1) and busy cycles seen.
  task automatic op(input bit w8,
                    input logic [7:0] a,
                    input logic [7:0] b,
                    output int edges,
                    output int bcnt);
    @(negedge clk);
    if (w8) begin
      dd8 = a; dv8 = b; st8 = 1'b1;
    end else begin
      dd4 = a[3:0]; dv4 = b[3:0]; st4 = 1'b1;
    end
    @(negedge clk);
    st4 = 1'b0;
    st8 = 1'b0;
    edges = 1;
    bcnt  = 0;
    while (!(w8 ? dn8 : dn4) && edges < 40) begin
      bcnt += int'(w8 ? bz8 : bz4);
      @(negedge clk);
      edges++;
    end
    if (edges >= 40) check("timeout", edges, 0);
    check("busy_with_done",
          int'(w8 ? bz8 : bz4), 0);
  endtask

  task automatic chk4(input string tag,
                      input int qe, input int re,
                      input int ee);
    check({tag, "_q"}, int'(q4), qe);
    check({tag, "_r"}, int'(r4), re);
    check({tag, "_e"}, int'(er4), ee);
  endtask

  int e, b, nd;
  logic [7:0] ra, rb;

  initial begin
    rst = 1'b1;
    st4 = 0; dd4 = 0; dv4 = 0;
    st8 = 0; dd8 = 0; dv8 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bz4), 0);
    check("rst_done", int'(dn4), 0);
    chk4("rst", 0, 0, 0);
    rst = 1'b0;

    op(0, 8'd8, 8'd2, e, b);
    check("8/2_edges", e, 5);
    chk4("8/2", 4, 0, 0);

    op(0, 8'd7, 8'd3, e, b);
    check("7/3_busy", b, 4);
    chk4("7/3", 2, 1, 0);

    op(0, 8'd6, 8'd0, e, b);
    check("6/0_edges", e, 2);
    check("6/0_busy", b, 0);
    chk4("6/0", 15, 6, 1);

    op(0, 8'd6, 8'd3, e, b);
    chk4("6/3", 2, 0, 0);

    op(0, 8'd3, 8'd7, e, b);
    chk4("3/7", 0, 3, 0);
    op(0, 8'd0, 8'd5, e, b);
    chk4("0/5", 0, 0, 0);
    op(0, 8'd15, 8'd1, e, b);
    chk4("15/1", 15, 0, 0);

    // second request during CALC must be dropped
    @(negedge clk);
    dd4 = 4'd13; dv4 = 4'd4; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    @(negedge clk);
    dd4 = 4'd1; dv4 = 4'd1; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    e = 3;
    while (!dn4 && e < 40) begin
      @(negedge clk);
      e++;
    end
    check("13/4_edges", e, 5);
    chk4("13/4", 3, 1, 0);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      nd += int'(dn4);
    end
    check("13/4_extra_done", nd, 0);

    // reset in the 2nd CALC cycle
    @(negedge clk);
    dd4 = 4'd15; dv4 = 4'd2; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", int'(bz4), 0);
    check("mid_rst_done", int'(dn4), 0);
    chk4("mid_rst", 0, 0, 0);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      nd += int'(dn4) + int'(bz4);
    end
    check("mid_rst_idle", nd, 0);

    op(0, 8'd9, 8'd4, e, b);
    chk4("9/4", 2, 1, 0);

    // start held high: back-to-back spacing N+2
    @(negedge clk);
    dd4 = 4'd7; dv4 = 4'd3; st4 = 1'b1;
    e = 0;
    do begin
      @(negedge clk);
      e++;
    end while (!dn4 && e < 40);
    check("b2b_first", e, 5);
    e = 0;
    do begin
      @(negedge clk);
      e++;
    end while (!dn4 && e < 40);
    st4 = 1'b0;
    check("b2b_gap", e, 6);
    chk4("b2b", 2, 1, 0);

    op(1, 8'd255, 8'd16, e, b);
    check("255/16_edges", e, 9);
    check("255/16_q", int'(q8), 15);
    check("255/16_r", int'(r8), 15);

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 8 == 3) ? 8'd0
                        : 8'($urandom_range(0, 255));
      op(1, ra, rb, e, b);
      if (rb == 0) begin
        check("rnd_q", int'(q8), 255);
        check("rnd_r", int'(r8), int'(ra));
        check("rnd_e", int'(er8), 1);
        check("rnd_edges", e, 2);
      end else begin
        check("rnd_q", int'(q8), int'(ra / rb));
        check("rnd_r", int'(r8), int'(ra % rb));
        check("rnd_e", int'(er8), 0);
        check("rnd_edges", e, 9);
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
